tart_reset_sequencer: RTL and testbench



---
 rtl/tart_reset_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_tart_reset_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tart_reset_sequencer.sv
// Fast-domain reset sequencer: qualifies DCM lock, holds, then releases reset.
// Optional DCM watchdog kick enabled by defining TART_RESET_WATCHDOG_EN.
module tart_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_CYCLES    = 1024,
  parameter int HOLD_CYCLES    = 16,
  parameter int LOSS_W         = 8,
  parameter int WDOG_CYCLES    = 65536,
  parameter int DCM_RST_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              locked_i,
  input  logic              clear_i,
  output logic              reset_o,
  output logic              ready_o,
  output logic              lock_lost_o,
  output logic [LOSS_W-1:0] loss_count_o,
  output logic              dcm_rst_o
);

  typedef enum logic [1:0] {
    S_WAIT,
    S_STABLE,
    S_HOLD,
    S_RUN
  } state_t;

  localparam int CNT_MAX = (LOCK_CYCLES > HOLD_CYCLES) ?
                           LOCK_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  // Elaboration-time guard on the minimum legal configuration
  if (SYNC_STAGES < 2 || LOCK_CYCLES < 2 || HOLD_CYCLES < 1 ||
      LOSS_W < 1 || WDOG_CYCLES < 2 || DCM_RST_CYCLES < 1)
  begin : g_bad_param
    $error("tart_reset_sequencer: parameter below minimum");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_loss;

  logic               r_reset;
  logic               r_ready;
  logic               r_lost;
  logic [LOSS_W-1:0]  r_lcnt;
  logic               w_reset_nxt;
  logic               w_ready_nxt;
  logic               w_lost_nxt;
  logic [LOSS_W-1:0]  w_lcnt_nxt;

  logic               w_kick;
  logic               w_dcm_busy;

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  // Bring the asynchronous lock indication into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], locked_i};
    end
  end

`ifdef TART_RESET_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES);
  localparam int DP_W = (DCM_RST_CYCLES > 1) ?
                        $clog2(DCM_RST_CYCLES) : 1;

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
  localparam logic [DP_W-1:0] DP_LAST = DP_W'(DCM_RST_CYCLES - 1);

  logic [WD_W-1:0] r_wd;
  logic [DP_W-1:0] r_dp_cnt;
  logic            r_dcm;
  logic            w_pre_hold;

  assign w_pre_hold = (r_state == S_WAIT) || (r_state == S_STABLE);
  // The wd counter is frozen during the pulse so kicks repeat every
  // WDOG_CYCLES + DCM_RST_CYCLES cycles while lock never arrives.
  assign w_kick     = w_pre_hold && !r_dcm && (r_wd == WD_LAST);
  assign w_dcm_busy = r_dcm;
  assign dcm_rst_o  = r_dcm;

  // Watchdog on lock acquisition and the DCM reset pulse it produces
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd     <= '0;
      r_dp_cnt <= '0;
      r_dcm    <= 1'b0;
    end else if (w_kick) begin
      r_wd     <= '0;
      r_dp_cnt <= '0;
      r_dcm    <= 1'b1;
    end else if (r_dcm) begin
      if (r_dp_cnt == DP_LAST) begin
        r_dcm <= 1'b0;
      end else begin
        r_dp_cnt <= r_dp_cnt + DP_W'(1);
      end
    end else if (w_pre_hold) begin
      if (w_state_nxt == S_HOLD) begin
        r_wd <= '0;
      end else begin
        r_wd <= r_wd + WD_W'(1);
      end
    end
  end
`else
  assign w_kick     = 1'b0;
  assign w_dcm_busy = 1'b0;
  assign dcm_rst_o  = 1'b0;
`endif

  // State register plus the registered outputs derived from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_WAIT;
      r_cnt   <= '0;
      r_reset <= 1'b1;
      r_ready <= 1'b0;
      r_lost  <= 1'b0;
      r_lcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_reset <= w_reset_nxt;
      r_ready <= w_ready_nxt;
      r_lost  <= w_lost_nxt;
      r_lcnt  <= w_lcnt_nxt;
    end
  end

  // Next-state: qualify lock, hold, run, and detect loss in RUN
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_loss      = 1'b0;
    if (w_kick) begin
      w_state_nxt = S_WAIT;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        S_WAIT: begin
          w_cnt_nxt = '0;
          if (w_lock_s && !w_dcm_busy) begin
            w_state_nxt = S_STABLE;
          end
        end
        S_STABLE: begin
          if (!w_lock_s) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = '0;
          end else if (r_cnt == LOCK_LAST) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (!w_lock_s) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = '0;
          end else if (r_cnt == HOLD_LAST) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!w_lock_s) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = '0;
            w_loss      = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs: reset/ready from next state, sticky loss flag and counter
  always_comb begin
    w_reset_nxt = (w_state_nxt != S_RUN);
    w_ready_nxt = (w_state_nxt == S_RUN);
    w_lost_nxt  = r_lost;
    w_lcnt_nxt  = r_lcnt;
    if (w_loss) begin
      w_lost_nxt = 1'b1;
      if (clear_i) begin
        w_lcnt_nxt = LOSS_W'(1);
      end else if (r_lcnt != {LOSS_W{1'b1}}) begin
        w_lcnt_nxt = r_lcnt + LOSS_W'(1);
      end
    end else if (clear_i) begin
      w_lost_nxt = 1'b0;
      w_lcnt_nxt = '0;
    end
  end

  assign reset_o      = r_reset;
  assign ready_o      = r_ready;
  assign lock_lost_o  = r_lost;
  assign loss_count_o = r_lcnt;

endmodule

// File: tb/tb_tart_reset_sequencer.sv
// Bench for tart_reset_sequencer: directed edge-exact checks plus random
// lock activity compared every cycle against a lock-streak model.
module tb_tart_reset_sequencer;

  localparam int SYNC   = 2;
  localparam int LCK    = 8;
  localparam int HLD    = 4;
  localparam int LW     = 2;
  localparam int WDG    = 32;
  localparam int DCMC   = 3;
  localparam int RUN_AT = LCK + HLD + 1;
  localparam int LMAX   = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          locked_i;
  logic          clear_i;
  logic          reset_o;
  logic          ready_o;
  logic          lock_lost_o;
  logic [LW-1:0] loss_count_o;
  logic          dcm_rst_o;

  int checks   = 0;
  int failures = 0;

  tart_reset_sequencer #(
    .SYNC_STAGES    (SYNC),
    .LOCK_CYCLES    (LCK),
    .HOLD_CYCLES    (HLD),
    .LOSS_W         (LW),
    .WDOG_CYCLES    (WDG),
    .DCM_RST_CYCLES (DCMC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .locked_i     (locked_i),
    .clear_i      (clear_i),
    .reset_o      (reset_o),
    .ready_o      (ready_o),
    .lock_lost_o  (lock_lost_o),
    .loss_count_o (loss_count_o),
    .dcm_rst_o    (dcm_rst_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: the system is released once lock_s has been seen high on
  // RUN_AT consecutive edges; a watchdog kick or a low sample restarts it.
  logic [SYNC-1:0] m_sync;
  int  m_streak;
  int  m_lcnt;
  bit  m_lost;
  int  m_wd;
  int  m_kick;
  bit  m_valid = 1'b0;

  always @(posedge clk) begin : model
    bit ls;
    bit was_run;
    bit busy;
    bit loss;
    int ns;
    if (rst) begin
      m_sync   = '0;
      m_streak = 0;
      m_lcnt   = 0;
      m_lost   = 1'b0;
      m_wd     = 0;
      m_kick   = 0;
      m_valid  = 1'b1;
    end else begin
      ls      = m_sync[SYNC-1];
      m_sync  = {m_sync[SYNC-2:0], locked_i};
      was_run = (m_streak >= RUN_AT);
      busy    = 1'b0;
      loss    = 1'b0;
`ifdef TART_RESET_WATCHDOG_EN
      if (m_kick > 0) begin
        m_kick--;
        busy = 1'b1;
      end else if (m_streak <= LCK && m_wd == WDG - 1) begin
        m_kick   = DCMC;
        m_wd     = 0;
        m_streak = 0;
        busy     = 1'b1;
      end
`endif
      if (!busy) begin
        ns = ls ? ((m_streak + 1 > RUN_AT) ? RUN_AT : m_streak + 1) : 0;
        if (m_streak <= LCK) m_wd = (ns == LCK + 1) ? 0 : m_wd + 1;
        loss     = was_run && !ls;
        m_streak = ns;
      end
      if (loss) begin
        m_lost = 1'b1;
        m_lcnt = clear_i ? 1 : ((m_lcnt < LMAX) ? m_lcnt + 1 : LMAX);
      end else if (clear_i) begin
        m_lost = 1'b0;
        m_lcnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_reset", int'(reset_o), int'(m_streak < RUN_AT));
      chk("m_ready", int'(ready_o), int'(m_streak >= RUN_AT));
      chk("m_lost", int'(lock_lost_o), int'(m_lost));
      chk("m_count", int'(loss_count_o), m_lcnt);
      chk("m_dcm", int'(dcm_rst_o), int'(m_kick > 0));
    end
  end

  initial begin
    rst      = 1'b1;
    locked_i = 1'b0;
    clear_i  = 1'b0;
    step(3);
    chk("rst_reset", int'(reset_o), 1);
    chk("rst_ready", int'(ready_o), 0);
    rst = 1'b0;
    step(100);
    chk("idle_reset", int'(reset_o), 1);
    chk("idle_ready", int'(ready_o), 0);
    chk("idle_lost", int'(lock_lost_o), 0);
    chk("idle_count", int'(loss_count_o), 0);
`ifndef TART_RESET_WATCHDOG_EN
    chk("idle_dcm", int'(dcm_rst_o), 0);
`endif

    // Release exactly after edge 14 counted from the first high sample
    rst = 1'b1;
    step(1);
    rst      = 1'b0;
    locked_i = 1'b1;
    step(14);
    chk("rel13_reset", int'(reset_o), 1);
    step(1);
    chk("rel14_reset", int'(reset_o), 0);
    chk("rel14_ready", int'(ready_o), 1);

    // Two-cycle drop during qualification restarts the count
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(6);
    locked_i = 1'b0;
    step(2);
    locked_i = 1'b1;
    step(14);
    chk("gl21_reset", int'(reset_o), 1);
    step(1);
    chk("gl22_reset", int'(reset_o), 0);
    chk("gl22_lost", int'(lock_lost_o), 0);

    // Repeated losses in RUN saturate the counter
    for (int i = 0; i < 4; i++) begin
      locked_i = 1'b0;
      step(2);
      chk("loss_k1_reset", int'(reset_o), 0);
      step(1);
      chk("loss_k2_reset", int'(reset_o), 1);
      chk("loss_k2_ready", int'(ready_o), 0);
      chk("loss_lost", int'(lock_lost_o), 1);
      chk("loss_count", int'(loss_count_o), (i + 1 > 3) ? 3 : i + 1);
      locked_i = 1'b1;
      step(16);
      chk("relock_ready", int'(ready_o), 1);
    end

    // Clear coincident with a loss: the loss wins
    locked_i = 1'b0;
    step(2);
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    chk("clrloss_count", int'(loss_count_o), 1);
    chk("clrloss_lost", int'(lock_lost_o), 1);
    locked_i = 1'b1;
    step(16);
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    chk("clr_count", int'(loss_count_o), 0);
    chk("clr_lost", int'(lock_lost_o), 0);

    // rst while in HOLD with cnt=2 restarts the whole sequence
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(13);
    rst = 1'b1;
    step(1);
    chk("hold_rst_reset", int'(reset_o), 1);
    rst = 1'b0;
    step(14);
    chk("hold13_reset", int'(reset_o), 1);
    step(1);
    chk("hold14_reset", int'(reset_o), 0);

    // Watchdog kicks while lock never arrives
    rst      = 1'b1;
    locked_i = 1'b0;
    step(1);
    rst = 1'b0;
`ifdef TART_RESET_WATCHDOG_EN
    step(31);
    chk("wd31", int'(dcm_rst_o), 0);
    step(1);
    chk("wd32", int'(dcm_rst_o), 1);
    step(2);
    chk("wd34", int'(dcm_rst_o), 1);
    step(1);
    chk("wd35", int'(dcm_rst_o), 0);
    step(31);
    chk("wd66", int'(dcm_rst_o), 0);
    step(1);
    chk("wd67", int'(dcm_rst_o), 1);
`else
    step(70);
    chk("nowd_dcm", int'(dcm_rst_o), 0);
`endif

    // Random lock activity with occasional clear and rst
    for (int blk = 0; blk < 200; blk++) begin
      int len;
      locked_i = ($urandom_range(0, 2) != 0);
      len = locked_i ? $urandom_range(5, 40) : $urandom_range(1, 6);
      for (int c = 0; c < len; c++) begin
        clear_i = ($urandom_range(0, 15) == 0);
        rst     = ($urandom_range(0, 299) == 0);
        step(1);
      end
    end
    rst     = 1'b0;
    clear_i = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
